// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: run-time selectable PRBS7/15/23/31 generator plus a self-synchronising
// checker that hunts for lock, then counts bit errors in a saturating counter.
//
// Handshake: gen_valid and chk_valid are plain valid strobes with no back-pressure.
// A word moves on every rising clk edge where its valid is high. There is no ready.
// gen_valid is high for exactly one cycle per word produced.
//
// rst_n is asynchronous and asserted HIGH, despite its name.
// The FSM state is visible on chk_locked, which is a direct decode of the state register.
module prbs_gen_chk #(
    parameter int DW         = 8,
    parameter int ERR_CNT_W  = 16,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 inv,
    input  logic                 reseed,
    input  logic                 gen_en,
    input  logic                 inj_err,
    output logic [DW-1:0]        gen_data,
    output logic                 gen_valid,
    input  logic [DW-1:0]        chk_data,
    input  logic                 chk_valid,
    input  logic                 err_clr,
    output logic                 chk_locked,
    output logic                 bit_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PC_W    = $clog2(DW + 1);
    localparam int SUM_W   = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;
    localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [SUM_W-1:0] ERR_MAX = (SUM_W'(1) << ERR_CNT_W) - SUM_W'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_fsm_t;

    chk_fsm_t             state_q, state_d;
    logic [30:0]          gen_state, gen_state_nxt;
    logic [30:0]          chk_state, chk_state_nxt;
    logic [DW-1:0]        gen_word;
    logic [DW-1:0]        chk_mis;
    logic [PC_W-1:0]      mis_cnt;
    logic [SUM_W-1:0]     err_sum;
    logic [ERR_CNT_W-1:0] err_sat;
    logic [CLEAN_W-1:0]   clean_q, clean_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 chk_step;
    logic                 g_hi, g_lo;
    logic                 c_hi, c_lo, c_rx, c_pred;

    // The reseed input overrides any checker word that arrives in the same cycle.
    assign chk_step   = chk_valid & ~reseed;
    assign chk_locked = (state_q == LOCKED);

    // Generator next word: DW serial LFSR steps unrolled. The first bit out lands in the word MSB.
    always_comb begin
        gen_state_nxt = gen_state;
        gen_word      = '0;
        g_hi          = 1'b0;
        g_lo          = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            case (mode)
                2'b00:   begin g_hi = gen_state_nxt[6];  g_lo = gen_state_nxt[5];  end
                2'b01:   begin g_hi = gen_state_nxt[14]; g_lo = gen_state_nxt[13]; end
                2'b10:   begin g_hi = gen_state_nxt[22]; g_lo = gen_state_nxt[17]; end
                default: begin g_hi = gen_state_nxt[30]; g_lo = gen_state_nxt[27]; end
            endcase
            gen_word[i]   = g_hi;
            gen_state_nxt = {gen_state_nxt[29:0], g_hi ^ g_lo};
        end
    end

    // Checker word: predict each bit from the local state and flag mismatches.
    // In HUNT the received bit is shifted in (self-sync). In LOCKED the predicted bit is
    // shifted in, so the state free-runs and a single flipped bit counts as a single error.
    always_comb begin
        chk_state_nxt = chk_state;
        chk_mis       = '0;
        c_hi          = 1'b0;
        c_lo          = 1'b0;
        c_rx          = 1'b0;
        c_pred        = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            case (mode)
                2'b00:   begin c_hi = chk_state_nxt[6];  c_lo = chk_state_nxt[5];  end
                2'b01:   begin c_hi = chk_state_nxt[14]; c_lo = chk_state_nxt[13]; end
                2'b10:   begin c_hi = chk_state_nxt[22]; c_lo = chk_state_nxt[17]; end
                default: begin c_hi = chk_state_nxt[30]; c_lo = chk_state_nxt[27]; end
            endcase
            c_rx          = chk_data[i] ^ inv;
            c_pred        = c_hi ^ c_lo;
            chk_mis[i]    = c_rx ^ c_pred;
            chk_state_nxt = {chk_state_nxt[29:0], (state_q == LOCKED) ? c_pred : c_rx};
        end
    end

    // Count the mismatching bits in the checked word.
    always_comb begin
        mis_cnt = '0;
        for (int i = 0; i < DW; i++) begin
            mis_cnt = mis_cnt + PC_W'(chk_mis[i]);
        end
    end

    // Saturating add. The sum is one bit wider than the counter, so the overflow is visible before clamping.
    always_comb begin
        err_sum = SUM_W'(err_cnt) + SUM_W'(mis_cnt);
        err_sat = (err_sum > ERR_MAX) ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
    end

    // Lock FSM next state: count clean words while hunting and errored words while locked.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        bad_d   = bad_q;
        if (reseed) begin
            state_d = HUNT;
            clean_d = '0;
            bad_d   = '0;
        end else if (chk_valid) begin
            case (state_q)
                HUNT: begin
                    bad_d = '0;
                    if (|chk_mis) begin
                        clean_d = '0;
                    end else if (clean_q == CLEAN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        clean_d = '0;
                    end else begin
                        clean_d = clean_q + CLEAN_W'(1);
                    end
                end
                default: begin
                    if (|chk_mis) begin
                        if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                            state_d = HUNT;
                            bad_d   = '0;
                            clean_d = '0;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end
    end

    // Lock FSM state and run-length counters.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= HUNT;
            clean_q <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
            bad_q   <= bad_d;
        end
    end

    // Generator registers. Inversion is applied first, then the injected flip on bit 0.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            gen_state <= 31'd1;
            gen_data  <= '0;
            gen_valid <= 1'b0;
        end else if (reseed) begin
            gen_state <= 31'd1;
            gen_valid <= 1'b0;
        end else if (gen_en) begin
            gen_state <= gen_state_nxt;
            gen_data  <= gen_word ^ {DW{inv}} ^ DW'(inj_err);
            gen_valid <= 1'b1;
        end else begin
            gen_valid <= 1'b0;
        end
    end

    // Checker LFSR state advances once per accepted word.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            chk_state <= 31'd1;
        end else if (reseed) begin
            chk_state <= 31'd1;
        end else if (chk_valid) begin
            chk_state <= chk_state_nxt;
        end
    end

    // Error reporting happens only while LOCKED. err_clr takes priority over an increment in the same cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bit_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            bit_err <= chk_step & (state_q == LOCKED) & (|chk_mis);
            if (err_clr) begin
                err_cnt <= '0;
            end else if (chk_step && state_q == LOCKED) begin
                err_cnt <= err_sat;
            end
        end
    end

endmodule
